// File: rtl/add8_err_monitor.sv
// ---------------------------------------------------------------------------
// add8_err_monitor
//
// Purpose:
//   Error-characterisation stage that sits directly downstream of an 8-bit
//   approximate adder. Each accepted sample carries the operands A and B and
//   the adder's result O. The stage recomputes the exact sum A+B and
//   accumulates error statistics over a run of num_samples samples:
//   - sample count
//   - error-occurrence count
//   - sum of absolute error
//   - optional sum of squared error
//   - worst-case error, with the operands that first produced it
//
// Optional feature (macro ERR_SQ_EN):
//   When ERR_SQ_EN is defined, the SSE_W parameter, the sse port, the
//   (W+1)x(W+1) squared-error multiply and the sse accumulator exist.
//   When it is undefined they are absent. Everything else, including
//   timing, is identical in both builds.
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst_n        synchronous active-low reset
//   start        one-cycle pulse: clear statistics and begin a run.
//                Honoured only in IDLE or DONE.
//   num_samples  run length; latched on an honoured start
//   s_valid      sample valid (input side)
//   s_ready      sample ready (output side); high exactly while in RUN
//   s_a, s_b     operands
//   s_o          approximate adder result (W+1 bits)
//   busy         high in RUN or DRAIN
//   done         high in DONE
//   sample_cnt   number of samples accumulated
//   err_cnt      number of samples with a nonzero error
//   sae          sum of |O - (A+B)|
//   sse          sum of (O - (A+B))^2  (ERR_SQ_EN builds only)
//   wce          maximum |error| seen so far
//   wce_a/wce_b  operands at the first occurrence of wce
//   dbg_state    current FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//
// Handshake:
//   A sample transfers on a rising edge where s_valid && s_ready.
//   s_valid may drop at any time and stay low for any number of cycles.
//   s_ready is decoded from the registered state. It therefore falls in
//   the cycle after the final accept, and it never depends on s_valid.
//
// Timing:
//   - Stage 1 registers the absolute error on the accept edge.
//   - Stage 2 folds that error into the statistics on the next edge.
//   - A sample's contribution is therefore visible two cycles after it
//     was accepted.
//   - DRAIN waits until both pipeline valid flags are clear. DONE follows
//     three edges after the final accept.
//   All accumulators saturate at all-ones instead of wrapping.
// ---------------------------------------------------------------------------
module add8_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 17,
  parameter int SAE_W = CNT_W + W + 1
`ifdef ERR_SQ_EN
  ,
  parameter int SSE_W = CNT_W + 2 * (W + 1)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_a,
  input  logic [W-1:0]     s_b,
  input  logic [W:0]       s_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SAE_W-1:0] sae,
`ifdef ERR_SQ_EN
  output logic [SSE_W-1:0] sse,
`endif
  output logic [W:0]       wce,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Run control
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_q;
  logic             accept;
  logic             start_run;
  logic             last_accept;

  // Stage 1
  logic             s1_v_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;
  logic [W:0]       s1_e_q;
  logic [W:0]       exact;
  logic signed [W+1:0] diff;
  logic [W:0]       e_d;

  // Stage 2
  logic             s2_v_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [SAE_W-1:0] sae_q;
  logic [W:0]       wce_q;
  logic [W-1:0]     wce_a_q;
  logic [W-1:0]     wce_b_q;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W:0]   err_sum;
  logic [SAE_W:0]   sae_sum;
`ifdef ERR_SQ_EN
  logic [SSE_W-1:0] sse_q;
  logic [2*W+1:0]   sq;
  logic [SSE_W:0]   sse_sum;
`endif

  assign accept      = s_valid && s_ready;
  assign start_run   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_accept = accept && ((acc_q + CNT_W'(1)) == num_q);

  // ---------------------------------------------------------------- FSM
  // Process 1 of 3: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Process 2 of 3: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // A zero-length run has nothing to accept.
          state_d = (num_samples == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_accept) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_v_q && !s2_v_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Process 3 of 3: outputs decoded from the state register.
  always_comb begin
    s_ready = (state_q == ST_RUN);
    busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done    = (state_q == ST_DONE);
  end

  assign dbg_state = state_q;

  // ------------------------------------------------------- run control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q <= '0;
      acc_q <= '0;
    end else if (start_run) begin
      num_q <= num_samples;
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= acc_q + CNT_W'(1);
    end
  end

  // ----------------------------------------------------------- stage 1
  // O is at most 2^(W+1)-1 and A+B is at most 2^(W+1)-2.
  // The signed difference therefore needs W+2 bits.
  // Its magnitude always fits in W+1 bits.
  always_comb begin
    exact = {1'b0, s_a} + {1'b0, s_b};
    diff  = $signed({1'b0, s_o}) - $signed({1'b0, exact});
    e_d   = diff[W+1] ? (W+1)'(-diff) : diff[W:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_e_q <= '0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= accept;
      s2_v_q <= s1_v_q;
      if (accept) begin
        s1_a_q <= s_a;
        s1_b_q <= s_b;
        s1_e_q <= e_d;
      end
    end
  end

  // ----------------------------------------------------------- stage 2
  // Each sum carries one extra bit.
  // A set top bit means the accumulator would wrap, so it pins at all-ones.
  always_comb begin
    cnt_sum = {1'b0, sample_cnt_q} + (CNT_W+1)'(1);
    err_sum = {1'b0, err_cnt_q} + (CNT_W+1)'(s1_e_q != '0);
    sae_sum = {1'b0, sae_q} + (SAE_W+1)'(s1_e_q);
  end

`ifdef ERR_SQ_EN
  always_comb begin
    sq      = {{(W+1){1'b0}}, s1_e_q} * {{(W+1){1'b0}}, s1_e_q};
    sse_sum = {1'b0, sse_q} + (SSE_W+1)'(sq);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sae_q        <= '0;
      wce_q        <= '0;
      wce_a_q      <= '0;
      wce_b_q      <= '0;
    end else if (start_run) begin
      // A new run is only honoured once the pipeline is empty,
      // so clearing here cannot race a stage-2 update.
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sae_q        <= '0;
      wce_q        <= '0;
      wce_a_q      <= '0;
      wce_b_q      <= '0;
    end else if (s1_v_q) begin
      sample_cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      err_cnt_q    <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      sae_q        <= sae_sum[SAE_W] ? '1 : sae_sum[SAE_W-1:0];
      // Strict compare: on a tie the first occurrence keeps its operands.
      if (s1_e_q > wce_q) begin
        wce_q   <= s1_e_q;
        wce_a_q <= s1_a_q;
        wce_b_q <= s1_b_q;
      end
    end
  end

`ifdef ERR_SQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sse_q <= '0;
    end else if (start_run) begin
      sse_q <= '0;
    end else if (s1_v_q) begin
      sse_q <= sse_sum[SSE_W] ? '1 : sse_sum[SSE_W-1:0];
    end
  end

  assign sse = sse_q;
`endif

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sae        = sae_q;
  assign wce        = wce_q;
  assign wce_a      = wce_a_q;
  assign wce_b      = wce_b_q;

endmodule

// File: tb/tb_add8_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_add8_err_monitor
//
// Self-checking bench for add8_err_monitor.
//   - Inputs are driven on the falling edge of clk.
//   - Outputs are sampled on the falling edge, before new inputs are driven.
//   - A table of short runs, each with hand-computed statistics, is applied
//     in a loop.
//   - Hand-written sequences then cover:
//       - two-cycle result latency
//       - zero-length runs
//       - a start pulse during RUN
//       - reset mid-run
//       - an exhaustive operand sweep through a behavioural approximate adder
// ---------------------------------------------------------------------------
module tb_add8_err_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 17;
  localparam int SAE_W = CNT_W + W + 1;
`ifdef ERR_SQ_EN
  localparam int SSE_W = CNT_W + 2 * (W + 1);
`endif

  // ------------------------------------------------ clock / reset block
  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_a;
  logic [W-1:0]     s_b;
  logic [W:0]       s_o;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [SAE_W-1:0] sae;
`ifdef ERR_SQ_EN
  logic [SSE_W-1:0] sse;
`endif
  logic [W:0]       wce;
  logic [W-1:0]     wce_a;
  logic [W-1:0]     wce_b;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  add8_err_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_a         (s_a),
    .s_b         (s_b),
    .s_o         (s_o),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sae         (sae),
`ifdef ERR_SQ_EN
    .sse         (sse),
`endif
    .wce         (wce),
    .wce_a       (wce_a),
    .wce_b       (wce_b),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_stats(input string tag,
                             input longint unsigned e_cnt, e_err, e_sae,
                             input longint unsigned e_sse, e_wce, e_wa, e_wb);
    exp_q.push_back(e_cnt);
    exp_q.push_back(e_err);
    exp_q.push_back(e_sae);
`ifdef ERR_SQ_EN
    exp_q.push_back(e_sse);
`endif
    exp_q.push_back(e_wce);
    exp_q.push_back(e_wa);
    exp_q.push_back(e_wb);
    check({tag, ".sample_cnt"}, sample_cnt, exp_q.pop_front());
    check({tag, ".err_cnt"},    err_cnt,    exp_q.pop_front());
    check({tag, ".sae"},        sae,        exp_q.pop_front());
`ifdef ERR_SQ_EN
    check({tag, ".sse"},        sse,        exp_q.pop_front());
`else
    if (e_sse > 64'hFFFF_FFFF_FFFF) $display("note: sse expectation unused");
`endif
    check({tag, ".wce"},        wce,        exp_q.pop_front());
    check({tag, ".wce_a"},      wce_a,      exp_q.pop_front());
    check({tag, ".wce_b"},      wce_b,      exp_q.pop_front());
  endtask

  // ------------------------------------------------------- driver tasks
  // All driver tasks are entered and left on a falling edge.
  task automatic start_pulse(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W:0] o);
    int n;
    s_a     = a;
    s_b     = b;
    s_o     = o;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      n_checks++;
      $display("FAIL send_timeout: s_ready got 0, expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1);
  endtask

  // Behavioural approximate adder for the sweep.
  // It under-reports the sum by exactly 2 whenever A[1:0] == 2'b11.
  function automatic logic [W:0] approx_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (a[1:0] == 2'b11) s = s - 9'd2;
    return s;
  endfunction

  // ------------------------------------------------------ vector table
  typedef struct {
    int              n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][8:0] o;
    longint unsigned cnt, err, sae, sse, wce, wa, wb;
  } run_t;

  run_t runs[4];

  task automatic set_vec(input int r, input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic [8:0] o);
    runs[r].a[i] = a;
    runs[r].b[i] = b;
    runs[r].o[i] = o;
  endtask

  task automatic set_exp(input int r, input int n,
                         input longint unsigned cnt, err, sae, sse,
                         input longint unsigned wce, wa, wb);
    runs[r].n   = n;
    runs[r].cnt = cnt;
    runs[r].err = err;
    runs[r].sae = sae;
    runs[r].sse = sse;
    runs[r].wce = wce;
    runs[r].wa  = wa;
    runs[r].wb  = wb;
  endtask

  // Run one table entry.
  // Also checks that done rises exactly three edges after the final accept.
  task automatic run_entry(input int r);
    string tag;
    tag = $sformatf("run%0d", r);
    start_pulse(runs[r].n);
    for (int i = 0; i < runs[r].n; i++) send(runs[r].a[i], runs[r].b[i], runs[r].o[i]);
    @(negedge clk);
    check({tag, ".busy_drain"}, busy, 1);
    check({tag, ".done_at_1"}, done, 0);
    @(negedge clk);
    check({tag, ".done_at_2"}, done, 0);
    @(negedge clk);
    check({tag, ".done_at_3"}, done, 1);
    check({tag, ".ready_low"}, s_ready, 0);
    check_stats(tag, runs[r].cnt, runs[r].err, runs[r].sae, runs[r].sse,
                runs[r].wce, runs[r].wa, runs[r].wb);
  endtask

  // ---------------------------------------------------------- main test
  initial begin
    // Run 0: exact adder, no error.
    set_vec(0, 0, 8'd3,   8'd1,   9'd4);
    set_vec(0, 1, 8'd255, 8'd255, 9'd510);
    set_vec(0, 2, 8'd0,   8'd0,   9'd0);
    set_vec(0, 3, 8'd128, 8'd127, 9'd255);
    set_exp(0, 4, 4, 0, 0, 0, 0, 0, 0);
    // Run 1: errors of 2 and 1.
    set_vec(1, 0, 8'd1, 8'd1, 9'd0);
    set_vec(1, 1, 8'd2, 8'd2, 9'd5);
    set_vec(1, 2, 8'd0, 8'd0, 9'd0);
    set_vec(1, 3, 8'd0, 8'd0, 9'd0);
    set_exp(1, 2, 2, 2, 3, 5, 2, 1, 1);
    // Run 2: three ties at |e|=3; the first occurrence keeps its operands.
    set_vec(2, 0, 8'd10, 8'd20, 9'd27);
    set_vec(2, 1, 8'd5,  8'd5,  9'd13);
    set_vec(2, 2, 8'd1,  8'd2,  9'd0);
    set_vec(2, 3, 8'd0,  8'd0,  9'd0);
    set_exp(2, 3, 3, 3, 9, 27, 3, 10, 20);
    // Run 3: extreme errors, +511 and -510.
    set_vec(3, 0, 8'd0,   8'd0,   9'd511);
    set_vec(3, 1, 8'd255, 8'd255, 9'd0);
    set_vec(3, 2, 8'd0,   8'd0,   9'd0);
    set_vec(3, 3, 8'd0,   8'd0,   9'd0);
    set_exp(3, 2, 2, 2, 1021, 521221, 511, 0, 0);

    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    s_valid     = 1'b0;
    s_a         = '0;
    s_b         = '0;
    s_o         = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.state", dbg_state, 0);
    check("rst.s_ready", s_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check_stats("rst", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int r = 0; r < 4; r++) run_entry(r);

    // Two-cycle contribution latency
    start_pulse(1);
    send(8'd5, 8'd5, 9'd12);
    check("lat.cnt_edge1", sample_cnt, 0);
    @(negedge clk);
    check("lat.cnt_edge2", sample_cnt, 1);
    check("lat.sae_edge2", sae, 2);
    @(negedge clk);
    check("lat.done_edge3", done, 0);
    @(negedge clk);
    check("lat.done_edge4", done, 1);

    // Zero-length run started from DONE
    start_pulse(0);
    check("zero.ready", s_ready, 0);
    check("zero.cleared_cnt", sample_cnt, 0);
    check("zero.cleared_sae", sae, 0);
    @(negedge clk);
    check("zero.done", done, 1);
    check("zero.ready_after", s_ready, 0);
    check_stats("zero", 0, 0, 0, 0, 0, 0, 0);

    // A start pulse during RUN is ignored
    start_pulse(10);
    for (int i = 0; i < 3; i++) send(8'(i * 7), 8'(i * 3 + 1), 9'(i * 10 + 1));
    start_pulse(5);
    check("ign.state_run", dbg_state, 1);
    for (int i = 3; i < 10; i++)
      send(8'(i * 7), 8'(i * 3 + 1), (i == 5) ? 9'd55 : 9'(i * 10 + 1));
    wait_done("ign.done");
    check_stats("ign", 10, 1, 4, 16, 4, 35, 16);

    // Reset for one cycle mid-run
    start_pulse(10);
    for (int i = 0; i < 3; i++) send(8'd1, 8'd1, 9'd0);
    check("mid.stats_nonzero", sample_cnt, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid.state", dbg_state, 0);
    check("mid.ready", s_ready, 0);
    check("mid.busy", busy, 0);
    check("mid.done", done, 0);
    check_stats("mid", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid.state_hold", dbg_state, 0);
    check("mid.cnt_hold", sample_cnt, 0);
    run_entry(1);

    // Exhaustive sweep with random s_valid gaps
    start_pulse(65536);
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        if ($urandom_range(0, 31) == 0) @(negedge clk);
        send(8'(a), 8'(b), approx_add(8'(a), 8'(b)));
      end
    end
    wait_done("sweep.done");
    check_stats("sweep", 65536, 16384, 32768, 65536, 2, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/add8_err_monitor.md
Name: add8_err_monitor

Overview:
Sequential error-characterisation stage placed directly downstream of an 8-bit approximate adder under test. Each cycle it accepts one operand pair together with the adder's 9-bit result, and recomputes the exact sum internally. It accumulates the library's error metrics over a run of N samples: sample count, error-occurrence count (EP), sum of absolute error (MAE), sum of squared error (MSE) and worst-case error (WCE) with the operands that produced it. Host software reads the counters after done to fill the circuit header figures.

Parameters:
W, 8, operand width; the adder result is W+1 bits
CNT_W, 17, width of the sample and error counters; holds 2^(2W) for an exhaustive sweep
SAE_W, CNT_W+W+1, width of the absolute-error accumulator
SSE_W, CNT_W+2*(W+1), width of the squared-error accumulator

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; clears statistics and begins a run
num_samples  in  CNT_W  samples in the run; latched on start
s_valid  in  1  sample valid
s_ready  out  1  sample ready
s_a  in  W  operand A
s_b  in  W  operand B
s_o  in  W+1  approximate adder output O
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
sample_cnt  out  CNT_W  samples accumulated
err_cnt  out  CNT_W  samples with nonzero error
sae  out  SAE_W  sum of |O - (A+B)|
sse  out  SSE_W  sum of (O - (A+B))^2; only present with ERR_SQ_EN
wce  out  W+1  maximum |error|
wce_a  out  W  A operand at first occurrence of wce
wce_b  out  W  B operand at first occurrence of wce

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; sampled only on the rising edge of clk.
- Reset: state IDLE; s_ready, busy and done are 0; every counter, accumulator, wce, wce_a and wce_b is 0; pipeline valid flags are 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE, start=1: clear all statistics, latch num_samples, clear the accepted counter. Go to RUN, or straight to DRAIN if num_samples==0.
  - RUN, on the accept that makes accepted==num_samples: go to DRAIN.
  - DRAIN, once both pipeline valid flags are 0: go to DONE.
  - start in RUN or DRAIN is ignored.
- s_ready = (state==RUN). It is registered from state, so it drops the cycle after the final accept. A sample is accepted on s_valid && s_ready. s_valid may gap arbitrarily; no samples are lost or duplicated.
- Stage 1, registered on accept:
  - exact = s_a + s_b, W+1 bits.
  - d = s_o - exact, signed W+2 bits.
  - e = |d|, W+1 bits; max 2^(W+1)-1 fits.
  - Stage 1 also carries s_a, s_b and the valid flag.
- Stage 2, on stage-1 valid:
  - sample_cnt += 1.
  - err_cnt += (e != 0).
  - sae += e.
  - sse += e*e.
  - If e > wce (strict), load wce=e, wce_a, wce_b. Ties keep the first occurrence.
- Latency: a sample's contribution is visible on the outputs 2 cycles after acceptance. done rises the cycle after the last contribution lands.
- Accumulators saturate at all-ones; they never wrap.
- Statistics hold after done until the next start or reset.
- Reset mid-run aborts the run. In-flight samples are discarded and all outputs return to reset values.

Optional Feature:
ERR_SQ_EN: when defined, the sse port, the squared-error datapath (a (W+1)x(W+1) multiply in stage 2) and the accumulator exist. When undefined, the sse port and its logic are absent; all other behaviour and timing are identical.

Test Plan:
- Exact-adder stimulus: num_samples=4, pairs (3,1,O=4), (255,255,O=510), (0,0,O=0), (128,127,O=255) -> err_cnt=0, sae=0, sse=0, wce=0, sample_cnt=4, done after last accept+3 cycles.
- Single error: num_samples=2, (1,1,O=0) then (2,2,O=5) -> err_cnt=2, sae=3, sse=5, wce=2, wce_a=1, wce_b=1.
- Exhaustive sweep of all 65536 pairs through add8_348, O fed back, with random s_valid gaps -> sample_cnt=65536, err_cnt=16384, sae=32768, sse=65536, wce=2.
- num_samples=0 with start -> s_ready never 1, DONE within 2 cycles, all statistics 0.
- start pulsed while in RUN after 3 of 10 samples -> ignored; run completes with sample_cnt=10.
- rst_n=0 for 1 cycle mid-run -> next cycle IDLE; all outputs 0; a subsequent start runs cleanly.
